cg_rr_dispatcher: RTL

- Collects single-cycle request pulses from up to WIDTH sources into a sticky pending vector.
- Issues one source index per handshake, in round-robin order, on a registered valid/ready output.
- Sits directly upstream of index consumers: issue queues, port muxes and wakeup logic. It drives the pending vector into priority encoders and turns the encoded result into a flow-controlled stream.
- No request is lost. A request that repeats while its bit is still pending is merged into that bit and counted.

---
 rtl/cg_rr_dispatcher_pkg.sv | 31 +++
 rtl/cg_priority_encoder.sv | 29 ++
 rtl/cg_rr_dispatcher.sv | 119 +++++++++++
 3 files changed

// File: rtl/cg_rr_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cg_rr_dispatcher_pkg
// Brief    : Shared types and helpers for the round-robin index dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package cg_rr_dispatcher_pkg;

    localparam int c_MAX_WIDTH = 256;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } out_state_e;

    function automatic int idx_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

    // Result is c_MAX_WIDTH wide; callers slice down to their own source count.
    function automatic logic [c_MAX_WIDTH-1:0] onehot(input int idx, input int width);
        logic [c_MAX_WIDTH-1:0] v;
        v = '0;
        if ((idx >= 0) && (idx < width)) begin
            v = c_MAX_WIDTH'(1) << idx;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cg_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : cg_priority_encoder
// Brief    : Lowest-set-index priority encoder with a found flag.
// Revision : 1.0 - initial release
// ============================================================================
module cg_priority_encoder #(
    parameter int BITS_WIDTH = 16,
    parameter int IDX_W      = 4
) (
    input  logic [BITS_WIDTH-1:0] i_bits,
    output logic [IDX_W-1:0]      o_index,
    output logic                  o_en
);

    // Scanning downward lets the lowest set bit overwrite the result last.
    always_comb begin
        o_index = '0;
        o_en    = 1'b0;
        for (int k = BITS_WIDTH - 1; k >= 0; k--) begin
            if (i_bits[k]) begin
                o_index = IDX_W'(k);
                o_en    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cg_rr_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : cg_rr_dispatcher
// Brief    : Sticky request collector issuing source indices round-robin on a
//            registered valid/ready stream, with a saturating merge counter.
// Revision : 1.0 - initial release
// ============================================================================
module cg_rr_dispatcher
    import cg_rr_dispatcher_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int CNT_W = 8,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_req,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index,
    output logic [WIDTH-1:0] o_pending,
    output logic [CNT_W-1:0] o_merge_cnt
);

    localparam logic [0:0] c_S_IDLE  = 1'(IDLE);
    localparam logic [0:0] c_S_OFFER = 1'(OFFER);
    localparam int         PC_W      = IDX_W + 1;
    localparam int         SUM_W     = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_pending;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_index;
    logic [CNT_W-1:0] r_cnt;

    logic                   w_hs;
    logic [c_MAX_WIDTH-1:0] w_served_full;
    logic [WIDTH-1:0]       w_served;
    logic [WIDTH-1:0]       w_pend_next;
    logic [WIDTH-1:0]       w_merge_vec;
    logic [IDX_W-1:0]       w_ptr_next;
    logic [WIDTH-1:0]       w_mask;
    logic [PC_W-1:0]        w_merges;
    logic [SUM_W-1:0]       w_sum;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [IDX_W-1:0]       w_idx_a;
    logic [IDX_W-1:0]       w_idx_b;
    logic                   w_en_a;
    logic                   w_en_b;
    logic [IDX_W-1:0]       w_sel;

    assign w_hs          = (r_state == c_S_OFFER) && i_ready;
    assign w_served_full = onehot(int'(r_index), WIDTH);
    assign w_served      = w_hs ? w_served_full[WIDTH-1:0] : '0;
    assign w_pend_next   = (r_pending & ~w_served) | i_req;
    assign w_merge_vec   = i_req & r_pending & ~w_served;

    assign w_ptr_next = !w_hs                        ? r_ptr :
                        (r_index == IDX_W'(WIDTH-1)) ? '0    :
                                                       r_index + IDX_W'(1);

    // Bits at or above the pointer; the wrap-around search uses the full vector.
    assign w_mask = ~((WIDTH'(1) << w_ptr_next) - WIDTH'(1));

    always_comb begin
        w_merges = '0;
        for (int k = 0; k < WIDTH; k++) begin
            w_merges = w_merges + PC_W'(w_merge_vec[k]);
        end
        w_sum      = SUM_W'(r_cnt) + SUM_W'(w_merges);
        w_cnt_next = (w_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    cg_priority_encoder #(
        .BITS_WIDTH (WIDTH),
        .IDX_W      (IDX_W)
    ) u_enc_masked (
        .i_bits  (w_pend_next & w_mask),
        .o_index (w_idx_a),
        .o_en    (w_en_a)
    );

    cg_priority_encoder #(
        .BITS_WIDTH (WIDTH),
        .IDX_W      (IDX_W)
    ) u_enc_full (
        .i_bits  (w_pend_next),
        .o_index (w_idx_b),
        .o_en    (w_en_b)
    );

    assign w_sel = w_en_a ? w_idx_a : w_idx_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= c_S_IDLE;
            r_pending <= '0;
            r_ptr     <= '0;
            r_index   <= '0;
            r_cnt     <= '0;
        end else begin
            r_pending <= w_pend_next;
            r_ptr     <= w_ptr_next;
            r_cnt     <= w_cnt_next;
            // An unaccepted offer stays frozen; otherwise reload from the selection.
            if ((r_state == c_S_IDLE) || w_hs) begin
                r_state <= w_en_b ? c_S_OFFER : c_S_IDLE;
                r_index <= w_sel;
            end
        end
    end

    assign o_valid     = (r_state == c_S_OFFER);
    assign o_index     = r_index;
    assign o_pending   = r_pending;
    assign o_merge_cnt = r_cnt;

endmodule
`default_nettype wire
